// File: rtl/instr_fetch_unit.sv
// Program counter and instruction register for the multi-cycle CPU.
// Computes the next PC from PCSel and fetches the word at PC over a req/ack handshake.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        pcWrite,
   input  logic        IRWrite,
   input  logic [1:0]  PCSel,
   input  logic [31:0] Immd,
   input  logic [31:0] RsData,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   output logic [31:0] PC,
   output logic [31:0] PCplus4,
   output logic [31:0] IR,
   output logic        fetchDone,
   output logic        fetchErr
);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam logic [1:0] SEL_NEXT = 2'b00;
   localparam logic [1:0] SEL_REL  = 2'b01;
   localparam logic [1:0] SEL_RS   = 2'b10;
   localparam logic [1:0] SEL_ABS  = 2'b11;

   // Last wait count before the request is abandoned; REQ lasts TIMEOUT cycles.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t             state;
   state_t             state_next;
   logic [7:0]         wait_cnt;
   logic               take_ack;
   logic               take_tmo;
   logic               pend_vld;
   logic [31:0]        pend_pc;
   logic [31:0]        pc_next;
   logic signed [31:0] rel_off;

   assign PCplus4  = PC + 32'd4;
   assign imemAddr = PC;
   assign rel_off  = $signed(Immd) <<< 2;

   always_comb begin
      pc_next = PCplus4;
      case (PCSel)
         SEL_NEXT: pc_next = PCplus4;
         SEL_REL:  pc_next = PCplus4 + $unsigned(rel_off);
         SEL_RS:   pc_next = RsData & 32'hFFFF_FFFC;
         SEL_ABS:  pc_next = {PCplus4[31:28], IR[25:0], 2'b00};
         default:  pc_next = PCplus4;
      endcase
   end

   always_comb begin
      state_next = state;
      take_ack   = 1'b0;
      take_tmo   = 1'b0;
      imemReq    = 1'b0;
      case (state)
         IDLE: begin
            if (IRWrite) state_next = REQ;
         end
         REQ: begin
            imemReq = 1'b1;
            // An ack arriving on the final allowed cycle still wins over the timeout.
            if (imemAck) begin
               take_ack   = 1'b1;
               state_next = IDLE;
            end else if (wait_cnt == LAST_CNT) begin
               take_tmo   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         wait_cnt  <= 8'd0;
         PC        <= RESET_PC;
         IR        <= 32'h0;
         fetchDone <= 1'b0;
         fetchErr  <= 1'b0;
         pend_vld  <= 1'b0;
      end else begin
         state     <= state_next;
         fetchDone <= take_ack | take_tmo;
         wait_cnt  <= (state == REQ) ? wait_cnt + 8'd1 : 8'd0;

         if (take_ack)      IR <= imemData;
         else if (take_tmo) IR <= 32'h0;

         if (take_tmo) fetchErr <= 1'b1;

         // PC must not move under an outstanding request, so writes are parked.
         if (state == REQ) begin
            if (pcWrite) pend_vld <= 1'b1;
         end else if (pcWrite) begin
            PC       <= pc_next;
            pend_vld <= 1'b0;
         end else if (pend_vld) begin
            PC       <= pend_pc;
            pend_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (state == REQ && pcWrite) pend_pc <= pc_next;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: next-PC selection, fetch handshake,
// deferred PC writes, timeout and reset abort.
module tb_instr_fetch_unit;

   logic        CLK;
   logic        RST;
   logic        pcWrite;
   logic        IRWrite;
   logic [1:0]  PCSel;
   logic [31:0] Immd;
   logic [31:0] RsData;
   logic        imemAck;
   logic [31:0] imemData;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] PC;
   logic [31:0] PCplus4;
   logic [31:0] IR;
   logic        fetchDone;
   logic        fetchErr;

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (4)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .pcWrite   (pcWrite),
      .IRWrite   (IRWrite),
      .PCSel     (PCSel),
      .Immd      (Immd),
      .RsData    (RsData),
      .imemAck   (imemAck),
      .imemData  (imemData),
      .imemReq   (imemReq),
      .imemAddr  (imemAddr),
      .PC        (PC),
      .PCplus4   (PCplus4),
      .IR        (IR),
      .fetchDone (fetchDone),
      .fetchErr  (fetchErr)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic set_pc(input logic [31:0] v);
      pcWrite = 1'b1; PCSel = 2'b10; RsData = v;
      tick;
      pcWrite = 1'b0; PCSel = 2'b00;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      tick; tick;
      RST = 1'b0;
      tick;
      checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
      checks++; if (IR !== 32'h0) begin failures++; $display("FAIL reset_ir: got %h want %h", IR, 32'h0); end
      checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imemReq); end
      checks++; if (fetchDone !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", fetchDone); end
      checks++; if (fetchErr !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", fetchErr); end
   endtask

   task automatic test_fetch;
      IRWrite = 1'b1;
      tick;
      IRWrite = 1'b0;
      checks++; if (imemReq !== 1'b1) begin failures++; $display("FAIL fetch_req: got %b want 1", imemReq); end
      checks++; if (imemAddr !== 32'h0) begin failures++; $display("FAIL fetch_addr: got %h want %h", imemAddr, 32'h0); end
      tick; tick;
      checks++; if (imemReq !== 1'b1 || fetchDone !== 1'b0) begin failures++; $display("FAIL fetch_wait: req=%b done=%b want 1/0", imemReq, fetchDone); end
      imemAck = 1'b1; imemData = 32'h2008_0005;
      tick;
      imemAck = 1'b0; imemData = 32'h0;
      checks++; if (IR !== 32'h2008_0005) begin failures++; $display("FAIL fetch_ir: got %h want %h", IR, 32'h2008_0005); end
      checks++; if (fetchDone !== 1'b1 || imemReq !== 1'b0) begin failures++; $display("FAIL fetch_done: done=%b req=%b want 1/0", fetchDone, imemReq); end
      tick;
      checks++; if (fetchDone !== 1'b0) begin failures++; $display("FAIL fetch_pulse: got %b want 0", fetchDone); end
      checks++; if (PC !== 32'h0) begin failures++; $display("FAIL fetch_pc: got %h want %h", PC, 32'h0); end
   endtask

   task automatic test_zero_wait;
      set_pc(32'h40);
      IRWrite = 1'b1;
      tick;
      IRWrite = 1'b0;
      checks++; if (imemAddr !== 32'h40) begin failures++; $display("FAIL zw_addr: got %h want %h", imemAddr, 32'h40); end
      imemAck = 1'b1; imemData = 32'h0800_0100;
      tick;
      imemAck = 1'b0;
      checks++; if (IR !== 32'h0800_0100 || fetchDone !== 1'b1) begin failures++; $display("FAIL zw_ir: ir=%h done=%b want %h/1", IR, fetchDone, 32'h0800_0100); end
      tick;
   endtask

   task automatic test_next_pc;
      pcWrite = 1'b1; PCSel = 2'b01; Immd = 32'hFFFF_FFFE;
      tick;
      pcWrite = 1'b0;
      checks++; if (PC !== 32'h3C) begin failures++; $display("FAIL rel_jmp: got %h want %h", PC, 32'h3C); end
      set_pc(32'h40);
      pcWrite = 1'b1; PCSel = 2'b10; RsData = 32'h1237;
      tick;
      pcWrite = 1'b0;
      checks++; if (PC !== 32'h1234) begin failures++; $display("FAIL rs_jmp: got %h want %h", PC, 32'h1234); end
      set_pc(32'h40);
      pcWrite = 1'b1; PCSel = 2'b11;
      tick;
      pcWrite = 1'b0;
      checks++; if (PC !== 32'h400) begin failures++; $display("FAIL abs_jmp: got %h want %h", PC, 32'h400); end
      set_pc(32'h40);
      pcWrite = 1'b1; PCSel = 2'b00;
      tick;
      pcWrite = 1'b0;
      checks++; if (PC !== 32'h44) begin failures++; $display("FAIL next_ins: got %h want %h", PC, 32'h44); end
      checks++; if (PCplus4 !== 32'h48) begin failures++; $display("FAIL pcplus4: got %h want %h", PCplus4, 32'h48); end
   endtask

   task automatic test_wrap;
      set_pc(32'hFFFF_FFFC);
      checks++; if (PCplus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4: got %h want %h", PCplus4, 32'h0); end
      pcWrite = 1'b1; PCSel = 2'b00;
      tick;
      pcWrite = 1'b0;
      checks++; if (PC !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want %h", PC, 32'h0); end
   endtask

   task automatic test_deferred;
      set_pc(32'h10);
      IRWrite = 1'b1;
      tick;
      IRWrite = 1'b0;
      pcWrite = 1'b1; PCSel = 2'b00;
      tick;
      pcWrite = 1'b0;
      checks++; if (imemAddr !== 32'h10 || PC !== 32'h10) begin failures++; $display("FAIL defer_hold: addr=%h pc=%h want 10/10", imemAddr, PC); end
      tick;
      checks++; if (imemAddr !== 32'h10 || imemReq !== 1'b1) begin failures++; $display("FAIL defer_addr: addr=%h req=%b want 10/1", imemAddr, imemReq); end
      imemAck = 1'b1; imemData = 32'h1234_5678;
      tick;
      imemAck = 1'b0;
      checks++; if (PC !== 32'h10 || fetchDone !== 1'b1) begin failures++; $display("FAIL defer_m1: pc=%h done=%b want 10/1", PC, fetchDone); end
      tick;
      checks++; if (PC !== 32'h14) begin failures++; $display("FAIL defer_apply: got %h want %h", PC, 32'h14); end
   endtask

   task automatic test_same_cycle;
      pcWrite = 1'b1; PCSel = 2'b00; IRWrite = 1'b1;
      tick;
      pcWrite = 1'b0; IRWrite = 1'b0;
      checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h18) begin failures++; $display("FAIL same_addr: req=%b addr=%h want 1/18", imemReq, imemAddr); end
      imemAck = 1'b1; imemData = 32'hAAAA_5555;
      tick;
      imemAck = 1'b0;
      checks++; if (IR !== 32'hAAAA_5555) begin failures++; $display("FAIL same_ir: got %h want %h", IR, 32'hAAAA_5555); end
      tick;
   endtask

   task automatic test_ack_ignored;
      imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
      tick;
      imemAck = 1'b0;
      checks++; if (IR !== 32'hAAAA_5555 || fetchDone !== 1'b0) begin failures++; $display("FAIL idle_ack: ir=%h done=%b want aaaa5555/0", IR, fetchDone); end
   endtask

   task automatic test_ack_at_limit;
      IRWrite = 1'b1;
      tick;
      IRWrite = 1'b0;
      tick; tick; tick;
      checks++; if (imemReq !== 1'b1) begin failures++; $display("FAIL limit_req: got %b want 1", imemReq); end
      imemAck = 1'b1; imemData = 32'h0000_0777;
      tick;
      imemAck = 1'b0;
      checks++; if (IR !== 32'h777 || fetchErr !== 1'b0 || fetchDone !== 1'b1) begin failures++; $display("FAIL limit_ack: ir=%h err=%b done=%b want 777/0/1", IR, fetchErr, fetchDone); end
      tick;
   endtask

   task automatic test_timeout;
      int n;
      IRWrite = 1'b1;
      tick;
      IRWrite = 1'b0;
      n = 0;
      while (imemReq === 1'b1 && n < 20) begin
         n++;
         tick;
      end
      checks++; if (n != 4) begin failures++; $display("FAIL tmo_len: got %0d want 4", n); end
      checks++; if (IR !== 32'h0 || fetchErr !== 1'b1 || fetchDone !== 1'b1) begin failures++; $display("FAIL tmo_state: ir=%h err=%b done=%b want 0/1/1", IR, fetchErr, fetchDone); end
      tick;
      IRWrite = 1'b1;
      tick;
      IRWrite = 1'b0;
      imemAck = 1'b1; imemData = 32'h0000_0888;
      tick;
      imemAck = 1'b0;
      checks++; if (IR !== 32'h888 || fetchErr !== 1'b1) begin failures++; $display("FAIL tmo_sticky: ir=%h err=%b want 888/1", IR, fetchErr); end
      tick;
   endtask

   task automatic test_reset_mid_req;
      set_pc(32'h80);
      IRWrite = 1'b1;
      tick;
      IRWrite = 1'b0;
      imemAck = 1'b1; imemData = 32'h1111_2222; RST = 1'b1;
      tick;
      imemAck = 1'b0; RST = 1'b0;
      checks++; if (imemReq !== 1'b0 || fetchDone !== 1'b0) begin failures++; $display("FAIL rst_req: req=%b done=%b want 0/0", imemReq, fetchDone); end
      checks++; if (IR !== 32'h0 || PC !== 32'h0 || fetchErr !== 1'b0) begin failures++; $display("FAIL rst_state: ir=%h pc=%h err=%b want 0/0/0", IR, PC, fetchErr); end
      tick;
      checks++; if (imemReq !== 1'b0 || fetchDone !== 1'b0 || IR !== 32'h0) begin failures++; $display("FAIL rst_after: req=%b done=%b ir=%h want 0/0/0", imemReq, fetchDone, IR); end
   endtask

   initial begin
      CLK = 1'b0; RST = 1'b1; pcWrite = 1'b0; IRWrite = 1'b0; PCSel = 2'b00;
      Immd = 32'h0; RsData = 32'h0; imemAck = 1'b0; imemData = 32'h0;
      test_reset;
      test_fetch;
      test_zero_wait;
      test_next_pc;
      test_wrap;
      test_deferred;
      test_same_cycle;
      test_ack_ignored;
      test_ack_at_limit;
      test_timeout;
      test_reset_mid_req;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and instruction-register stage that sits directly upstream of the control unit in the multi-cycle CPU. It holds the PC and computes the next PC from the control unit's `PCSel`/`pcWrite` outputs. On `IRWrite` it fetches the word at PC from instruction memory over a ready/acknowledge handshake and latches it into the IR. The IR's `Op`/`Func` fields feed the control unit and state sequencer.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `TIMEOUT`, default 15: maximum cycles spent in REQ waiting for `imemAck` before abandoning the fetch (legal range 1..255).

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `pcWrite` in 1: commit next PC this cycle.
- `IRWrite` in 1: start an instruction fetch at current PC.
- `PCSel` in 2: next-PC source. 00 NextIns, 01 RelJmp, 10 RsJmp, 11 AbsJmp.
- `Immd` in 32: extended immediate (word offset) for RelJmp.
- `RsData` in 32: register rs value for RsJmp.
- `imemAck` in 1: memory has valid `imemData` this cycle.
- `imemData` in 32: instruction word from memory.
- `imemReq` out 1: fetch request, held until ack or timeout.
- `imemAddr` out 32: fetch address, equals PC.
- `PC` out 32: current program counter.
- `PCplus4` out 32: PC+4, combinational. Also the JAL link value.
- `IR` out 32: instruction register; `Op`=IR[31:26], `Func`=IR[5:0].
- `fetchDone` out 1: one-cycle pulse when IR has been loaded.
- `fetchErr` out 1: sticky fetch-timeout flag.

## Operation
- Next PC, all arithmetic modulo 2^32 with no overflow detection:
  - NextIns: PC+4.
  - RelJmp: PC+4+(Immd<<2).
  - RsJmp: RsData.
  - AbsJmp: {PCplus4[31:28], IR[25:0], 2'b00}.
- PC updates only on `pcWrite`=1. Low 2 bits of a RsJmp target are forced to 00.
- Fetch FSM states:
  - IDLE: `imemReq`=0. `IRWrite`=1 goes to REQ and clears the wait counter.
  - REQ: `imemReq`=1, `imemAddr`=PC, counter increments each cycle.
    - `imemAck`=1: IR<=`imemData`, `fetchDone` pulses next cycle, go to IDLE.
    - Counter reaches `TIMEOUT` without ack: IR<=32'h0 (NOP), `fetchErr`<=1, `fetchDone` pulses, go to IDLE.
- `IRWrite` while in REQ is ignored; no queuing.
- `pcWrite` while in REQ: the computed next PC is latched into a pending register (a later `pcWrite` overwrites it). The pending value is applied in the cycle after leaving REQ. `imemAddr` stays stable for the whole request.
- `pcWrite` and `IRWrite` in the same IDLE cycle: PC updates, and the fetch uses the new PC (REQ begins next cycle).
- `fetchErr` clears only on `RST`.

## Timing
- Reset values (during and immediately after `RST`):
  - PC=`RESET_PC`, IR=0, state IDLE.
  - `imemReq`=0, `fetchDone`=0, `fetchErr`=0, pending flag 0.
- `RST` mid-request aborts the request: `imemReq` is low the cycle after the reset edge, and IR is not written.
- Latencies:
  - `IRWrite` at cycle n gives `imemReq` high from cycle n+1.
  - Ack in cycle m loads IR at the end of m, with `fetchDone` high in m+1.
  - Zero-wait memory (ack in n+1) gives IR valid and `fetchDone` in n+2.
  - `pcWrite` in cycle n makes PC valid in n+1. If deferred, it is valid 2 cycles after the ack cycle.
- `imemAck` is ignored outside REQ.
- An ack in the same cycle the counter hits `TIMEOUT` counts as success: no error.

## Test plan
- Reset, then `IRWrite` with ack after 2 waits and imemData=32'h2008_0005 -> `imemAddr`=0, IR=32'h2008_0005, one `fetchDone` pulse, PC=0.
- PC=0x40, `pcWrite` with each `PCSel` in turn: Immd=-2 gives RelJmp 0x3C; RsData=0x1237 gives RsJmp 0x1234; IR[25:0]=0x100 gives AbsJmp 0x400; NextIns gives 0x44.
- PC=0xFFFF_FFFC with NextIns -> PC=0x0000_0000 (wrap).
- `pcWrite` (NextIns, PC=0x10) during REQ -> `imemAddr` stays 0x10 until ack; PC=0x14 two cycles after the ack.
- No ack with `TIMEOUT`=4 -> `imemReq` high exactly 4 cycles, IR=0, `fetchErr`=1 and sticky across later successful fetches.
- `RST` asserted in REQ with ack arriving in the same cycle -> IR stays 0, PC=`RESET_PC`, `imemReq`=0 next cycle.
